// File: rtl/karatsuba_seq_ctrl_52bit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | karatsuba_seq_ctrl_52bit_pkg : widths and FSM encoding shared by the  |
// | sequential Karatsuba carry-less multiplier.      Revision: 1.0       |
// +----------------------------------------------------------------------+
package karatsuba_seq_ctrl_52bit_pkg;

  localparam int N  = 52;        // operand width (even)
  localparam int H  = N / 2;     // half width
  localparam int PW = 2 * N - 1; // full product width
  localparam int SW = 2 * H - 1; // sub-product width

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_LO  = 3'd1,
    MUL_HI  = 3'd2,
    MUL_MID = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/clmul_26bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clmul_26bit : combinational 26x26 carry-less (GF(2)) multiplier.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module clmul_26bit
  import karatsuba_seq_ctrl_52bit_pkg::*;
(
  input  logic [H-1:0]  i_a,
  input  logic [H-1:0]  i_b,
  output logic [SW-1:0] o_p
);

  always_comb begin
    o_p = '0;
    for (int i = 0; i < H; i++) begin
      if (i_b[i]) begin
        o_p = o_p ^ ({{(SW-H){1'b0}}, i_a} << i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/karatsuba_seq_ctrl_52bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | karatsuba_seq_ctrl_52bit : 52x52 carry-less multiply, one shared      |
// | 26x26 multiplier reused for lo/hi/mid products.   Revision: 1.0      |
// +----------------------------------------------------------------------+
module karatsuba_seq_ctrl_52bit
  import karatsuba_seq_ctrl_52bit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] c_out,
  output logic          busy
);

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [SW-1:0] r_plo;
  logic [SW-1:0] r_phi;
  logic [PW-1:0] r_c;
  logic [H-1:0]  w_mul_a;
  logic [H-1:0]  w_mul_b;
  logic [SW-1:0] w_prod;
  logic [SW-1:0] w_mid;
  logic [PW-1:0] w_comb;

  clmul_26bit u_clmul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      IDLE: begin
        if (in_valid) w_next = MUL_LO;
      end
      MUL_LO: begin
        w_mul_a = r_a[H-1:0];
        w_mul_b = r_b[H-1:0];
        w_next  = MUL_HI;
      end
      MUL_HI: begin
        w_mul_a = r_a[N-1:H];
        w_mul_b = r_b[N-1:H];
        w_next  = MUL_MID;
      end
      MUL_MID: begin
        w_mul_a = r_a[H-1:0] ^ r_a[N-1:H];
        w_mul_b = r_b[H-1:0] ^ r_b[N-1:H];
        w_next  = DONE;
      end
      DONE: begin
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // In MUL_MID the multiplier output is the raw middle product pm.
  assign w_mid  = w_prod ^ r_plo ^ r_phi;
  assign w_comb = {{(PW-SW){1'b0}}, r_plo}
                ^ ({{(PW-SW){1'b0}}, w_mid} << H)
                ^ ({{(PW-SW){1'b0}}, r_phi} << N);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_plo <= '0;
      r_phi <= '0;
      r_c   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a <= a_in;
            r_b <= b_in;
          end
        end
        MUL_LO:  r_plo <= w_prod;
        MUL_HI:  r_phi <= w_prod;
        MUL_MID: r_c   <= w_comb;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign c_out     = r_c;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_seq_ctrl_52bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_karatsuba_seq_ctrl_52bit : directed self-checking bench for the   |
// | sequential Karatsuba carry-less multiplier.       Revision: 1.0      |
// +----------------------------------------------------------------------+
module tb_karatsuba_seq_ctrl_52bit;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [51:0]   a_in = '0;
  logic [51:0]   b_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [102:0]  c_out;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  karatsuba_seq_ctrl_52bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [102:0] clmul_ref(input logic [51:0] a, input logic [51:0] b);
    logic [102:0] r;
    r = '0;
    for (int i = 0; i < 52; i++)
      if (b[i]) r = r ^ ({51'b0, a} << i);
    return r;
  endfunction

  // Stimulus only: accepts one operand pair and returns latency and product.
  task automatic run_op(input logic [51:0] a, input logic [51:0] b,
                        output int lat, output logic [102:0] res);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    res = c_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (c_out !== 103'd0) begin n_fail++; $display("FAIL reset_c_out got=%h exp=0", c_out); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int lat;
    logic [102:0] res;
    out_ready = 1'b1;
    run_op(52'h3, 52'h3, lat, res);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    n_checks++; if (res !== 103'h5) begin n_fail++; $display("FAIL basic_3x3 got=%h exp=5", res); end
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_return_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    run_op(52'hFFFFFFFFFFFFF, 52'h1, lat, res);
    n_checks++; if (res !== 103'hFFFFFFFFFFFFF) begin n_fail++; $display("FAIL basic_ones_x1 got=%h exp=fffffffffffff", res); end
    tick();
  endtask

  task automatic test_cross_half();
    int lat;
    logic [102:0] res;
    run_op(52'd1 << 26, 52'd1 << 25, lat, res);
    n_checks++; if (res !== (103'd1 << 51)) begin n_fail++; $display("FAIL cross_mid_only got=%h exp=%h", res, 103'd1 << 51); end
    tick();
    run_op(52'd1 << 51, 52'd1 << 51, lat, res);
    n_checks++; if (res !== (103'd1 << 102)) begin n_fail++; $display("FAIL cross_top_bit got=%h exp=%h", res, 103'd1 << 102); end
    tick();
    run_op((52'd1 << 26) | 52'd1, (52'd1 << 26) | 52'd1, lat, res);
    n_checks++; if (res !== ((103'd1 << 52) | 103'd1)) begin n_fail++; $display("FAIL cross_cancel got=%h exp=%h", res, (103'd1 << 52) | 103'd1); end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in      = 52'h5;
    b_in      = 52'h3;
    tick();
    a_in = 52'h7; // held valid while busy: must be ignored
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL bp_latency got=%0d exp=3", n); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (out_valid !== 1'b1 || c_out !== 103'hF || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d out_valid=%b c_out=%h in_ready=%b exp 1/f/0", i, out_valid, c_out, in_ready); end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    n_checks++; if (c_out !== 103'hF) begin n_fail++; $display("FAIL bp_retain got=%h exp=f", c_out); end
  endtask

  task automatic test_back_to_back();
    logic [51:0]  ta [3];
    logic [51:0]  tb [3];
    logic [102:0] ex [3];
    int idx, chk, last_acc;
    bit acc;
    ta[0] = 52'hA5A5A5A5A5A5A; tb[0] = 52'h123456789ABCD;
    ta[1] = 52'hFEDCBA9876543; tb[1] = 52'h0F0F0F0F0F0F0;
    ta[2] = 52'h8000000000001; tb[2] = 52'hFFFFFFFFFFFFF;
    for (int k = 0; k < 3; k++) ex[k] = clmul_ref(ta[k], tb[k]);
    out_ready = 1'b1;
    idx = 0; chk = 0; last_acc = -1;
    in_valid = 1'b1; a_in = ta[0]; b_in = tb[0];
    for (int t = 0; t < 40 && chk < 3; t++) begin
      acc = 1'b0;
      if (out_valid) begin
        n_checks++; if (c_out !== ex[chk]) begin n_fail++; $display("FAIL b2b_result%0d got=%h exp=%h", chk, c_out, ex[chk]); end
        chk++;
      end
      if (in_ready && in_valid) begin
        if (last_acc >= 0) begin
          n_checks++; if (t - last_acc !== 5) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=5", t - last_acc); end
        end
        last_acc = t;
        acc = 1'b1;
      end
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) begin a_in = ta[idx]; b_in = tb[idx]; end
        else in_valid = 1'b0;
      end
    end
    n_checks++; if (chk !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", chk); end
    tick();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [102:0] res;
    in_valid = 1'b1;
    a_in = 52'hFFFFFFFFFFFFF;
    b_in = 52'hFFFFFFFFFFFFF;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midop_busy got=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midop_idle in_ready=%b busy=%b out_valid=%b exp 1/0/0", in_ready, busy, out_valid); end
    n_checks++; if (c_out !== 103'd0) begin n_fail++; $display("FAIL midop_c_out got=%h exp=0", c_out); end
    run_op(52'h3, 52'h3, lat, res);
    n_checks++; if (lat !== 3 || res !== 103'h5) begin
      n_fail++; $display("FAIL midop_after lat=%0d c_out=%h exp 3/5", lat, res); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cross_half();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
